// File: rtl/fp_wb_pkg.sv
// Shared types and constants for the FP writeback block: the buffered
// {destination, data} entry and the FP register-file geometry.
package fp_wb_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int FP_REG_COUNT = 32;
  localparam int RD_WIDTH     = $clog2(FP_REG_COUNT);

  typedef struct packed {
    logic [RD_WIDTH-1:0]   rd;
    logic [DATA_WIDTH-1:0] data;
  } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// First-word-fall-through FIFO of FP writeback entries. The head is readable
// in the cycle after it is written, so an idle FIFO adds one cycle of latency.
module fp_wb_fifo
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fp_wb_entry_t     push_entry,
  input  logic             pop,
  output fp_wb_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fp_wb_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  // Guards make the FIFO safe against a careless caller.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_fp_writeback.sv
// FP register-file write port: loads take priority over buffered FPU results,
// and a per-register scoreboard tracks outstanding writes for hazard stalls.
module wb_fp_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  output logic [31:0]           busy_vec,
  input  logic                  ld_valid,
  input  logic [4:0]            ld_rd,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  fpu_valid,
  output logic                  fpu_ready,
  input  logic [4:0]            fpu_rd,
  input  logic [DATA_WIDTH-1:0] fpu_data,
  output logic                  reg_write,
  output logic [4:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  import fp_wb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fp_wb_entry_t          fpu_entry;
  fp_wb_entry_t          fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_push;
  logic                  fifo_pop;

  logic                  reg_write_reg;
  logic                  reg_write_next;
  logic [4:0]            rd_addr_reg;
  logic [4:0]            rd_addr_next;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic [DATA_WIDTH-1:0] rd_data_next;
  logic [31:0]           busy_reg;
  logic [31:0]           busy_next;

  // Ready depends only on registered occupancy, never on fpu_valid.
  assign fpu_ready      = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_push      = fpu_valid && !fifo_full;
  assign fpu_entry.rd   = fpu_rd;
  assign fpu_entry.data = fpu_data;

  fp_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_entry(fpu_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    reg_write_next = 1'b0;
    rd_addr_next   = rd_addr_reg;
    rd_data_next   = rd_data_reg;
    fifo_pop       = 1'b0;
    if (ld_valid) begin
      reg_write_next = 1'b1;
      rd_addr_next   = ld_rd;
      rd_data_next   = ld_data;
    end else if (!fifo_empty) begin
      fifo_pop       = 1'b1;
      reg_write_next = 1'b1;
      rd_addr_next   = fifo_head.rd;
      rd_data_next   = fifo_head.data;
    end
  end

  // A new issue to a register outranks the retiring write to that register.
  for (genvar gi = 0; gi < FP_REG_COUNT; gi++) begin : g_busy
    assign busy_next[gi] = (issue_valid && issue_rd == 5'(gi)) ? 1'b1 :
                           (reg_write_reg && rd_addr_reg == 5'(gi)) ? 1'b0 :
                           busy_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_reg <= 1'b0;
      rd_addr_reg   <= '0;
      rd_data_reg   <= '0;
      busy_reg      <= '0;
    end else begin
      reg_write_reg <= reg_write_next;
      rd_addr_reg   <= rd_addr_next;
      rd_data_reg   <= rd_data_next;
      busy_reg      <= busy_next;
    end
  end

  assign reg_write = reg_write_reg;
  assign rd_addr   = rd_addr_reg;
  assign rd_data   = rd_data_reg;
  assign busy_vec  = busy_reg;

endmodule

// File: tb/tb_wb_fp_writeback.sv
// Self-checking bench for wb_fp_writeback: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a queue model.
module tb_wb_fp_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy_vec;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  logic [36:0] mq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_busy = '0;

  logic [36:0] wr_log[$];

  always #5 clk = ~clk;

  wb_fp_writeback #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_vec(busy_vec),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
    .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a write slot fed by the load if present, else the oldest buffered
  // FPU result; a bounded queue of accepted FPU results; a set of busy registers.
  always @(posedge clk) begin
    logic [36:0] e;
    logic [31:0] nb;
    bit          room;
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0; m_busy = '0;
    end else begin
      nb = m_busy;
      if (m_we) nb[m_addr] = 1'b0;
      if (issue_valid) nb[issue_rd] = 1'b1;
      room = (mq.size() < DEPTH);
      if (ld_valid) begin
        m_we = 1'b1; m_addr = ld_rd; m_data = ld_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1'b1; m_addr = e[36:32]; m_data = e[31:0];
      end else begin
        m_we = 1'b0;
      end
      if (fpu_valid && room) mq.push_back({fpu_rd, fpu_data});
      m_busy = nb;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("reg_write", reg_write, m_we);
      check("busy_vec", busy_vec, m_busy);
      check("fpu_ready", fpu_ready, mq.size() < DEPTH);
      if (m_we) begin
        check("rd_addr", rd_addr, m_addr);
        check("rd_data", rd_data, m_data);
      end
      if (reg_write === 1'b1) begin
        wr_log.push_back({rd_addr, rd_data});
        $display("write f%0d <= %08h", rd_addr, rd_data);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    fpu_valid = 1'b0; fpu_rd = '0; fpu_data = '0;
  endtask

  task automatic rand_inputs(input int p_ld, input int p_fpu, input int p_iss);
    issue_valid = ($urandom_range(99) < p_iss);
    issue_rd    = 5'($urandom);
    ld_valid    = ($urandom_range(99) < p_ld);
    ld_rd       = 5'($urandom);
    ld_data     = $urandom;
    fpu_valid   = ($urandom_range(99) < p_fpu);
    fpu_rd      = 5'($urandom);
    fpu_data    = $urandom;
  endtask

  initial begin
    int nxt;
    bit acc;
    logic [36:0] ref_q[$];
    logic [4:0] exp_rds[10];

    // Reset with random inputs
    rst = 1'b1;
    rand_inputs(50, 50, 50);
    tick();
    rand_inputs(50, 50, 50);
    tick();
    check("rst reg_write", reg_write, 0);
    check("rst rd_addr", rd_addr, 0);
    check("rst rd_data", rd_data, 0);
    check("rst busy_vec", busy_vec, 0);
    check("rst fpu_ready", fpu_ready, 1);
    rst = 1'b0;
    idle();
    chk_en = 1'b1;
    tick();

    // Load path
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    check("load busy c1", busy_vec[5], 1);
    tick();
    check("load busy c2", busy_vec[5], 1);
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h3F80_0000;
    tick();
    ld_valid = 1'b0;
    check("load reg_write", reg_write, 1);
    check("load rd_addr", rd_addr, 5);
    check("load rd_data", rd_data, 32'h3F80_0000);
    check("load model data", m_data, 32'h3F80_0000);
    check("load busy c3", busy_vec[5], 1);
    tick();
    check("load busy c4", busy_vec[5], 0);
    check("load idle", reg_write, 0);
    check("load hold addr", rd_addr, 5);

    // Priority: same-cycle load and FPU result
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h1;
    fpu_valid = 1'b1; fpu_rd = 5'd2; fpu_data = 32'h2;
    check("prio fpu_ready", fpu_ready, 1);
    tick();
    idle();
    check("prio first addr", rd_addr, 1);
    check("prio first data", rd_data, 32'h1);
    tick();
    check("prio second we", reg_write, 1);
    check("prio second addr", rd_addr, 2);
    check("prio second data", rd_data, 32'h2);
    tick();
    check("prio drained", reg_write, 0);
    repeat (2) tick();

    // Backpressure: loads hold the write port while FPU results pile up
    wr_log.delete();
    nxt = 8;
    for (int c = 0; c < 40 && nxt <= 12; c++) begin
      ld_valid = (c < 5); ld_rd = 5'(20 + c); ld_data = 32'(c);
      fpu_valid = 1'b1; fpu_rd = 5'(nxt); fpu_data = 32'(32'hF00 + nxt);
      acc = fpu_ready;
      tick();
      if (acc) nxt++;
      if (c == 3) check("bp ready after 4th accept", fpu_ready, 0);
    end
    if (nxt <= 12) check("bp accept timeout", 64'(nxt), 13);
    idle();
    repeat (6) tick();
    exp_rds = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
    check("bp write count", 64'(wr_log.size()), 10);
    for (int i = 0; i < 10 && i < wr_log.size(); i++)
      check("bp write order", wr_log[i][36:32], exp_rds[i]);

    // Scoreboard collision on f7
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
    tick();
    ld_valid = 1'b0;
    check("coll write on port", {reg_write, rd_addr}, {1'b1, 5'd7});
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    check("coll busy kept", busy_vec[7], 1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h78;
    tick();
    ld_valid = 1'b0;
    check("coll second write", reg_write, 1);
    tick();
    check("coll busy cleared", busy_vec[7], 0);
    repeat (2) tick();

    // Wrap-around stream of 20 FPU results
    wr_log.delete();
    ref_q.delete();
    for (int i = 0; i < 20; i++) begin
      fpu_valid = 1'b1; fpu_rd = 5'(i); fpu_data = $urandom;
      ref_q.push_back({fpu_rd, fpu_data});
      check("wrap ready", fpu_ready, 1);
      tick();
    end
    idle();
    check("wrap count before last", 64'(wr_log.size()), 19);
    tick();
    check("wrap count", 64'(wr_log.size()), 20);
    tick();
    check("wrap done", reg_write, 0);
    for (int i = 0; i < 20 && i < wr_log.size(); i++)
      check("wrap entry", wr_log[i], ref_q[i]);

    // Reset with three buffered results and f1..f3 pending
    for (int i = 1; i <= 3; i++) begin
      ld_valid = 1'b1; ld_rd = 5'd30; ld_data = 32'(i);
      fpu_valid = 1'b1; fpu_rd = 5'(i); fpu_data = 32'(i);
      issue_valid = 1'b1; issue_rd = 5'(i);
      tick();
    end
    idle();
    check("rstmid busy before", busy_vec, 32'h0000_000E);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid reg_write", reg_write, 0);
    check("rstmid busy", busy_vec, 0);
    check("rstmid fpu_ready", fpu_ready, 1);
    tick();
    check("rstmid fifo empty", reg_write, 0);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      if (i < 300) rand_inputs(30, 60, 30);
      else         rand_inputs(60, 80, 40);
      tick();
    end
    idle();
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/wb_fp_writeback.md
# wb_fp_writeback

Writeback-side driver for the floating-point register file. Merges FP results from the load path and the multi-cycle FPU into a single registered write port (`reg_write`/`rd_addr`/`rd_data`) feeding the FP register file. Maintains a per-register pending-write scoreboard so ID can stall on FP read-after-write hazards. Sits between MEM/FPU and the FP register file.

## Interface
Parameters:
- `DATA_WIDTH`, 32, FP register width (matches `` `DATA_WIDTH ``)
- `FIFO_DEPTH`, 4, FPU result buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; **synchronous, active-high**
- `issue_valid`  in  1  ID issues an instruction with an FP destination
- `issue_rd`  in  5  its destination FP register
- `busy_vec`  out  32  bit r = 1: write to f[r] outstanding
- `ld_valid`  in  1  load result valid; always accepted
- `ld_rd`  in  5  load destination
- `ld_data`  in  DATA_WIDTH  load data
- `fpu_valid`  in  1  FPU result valid
- `fpu_ready`  out  1  buffer can accept
- `fpu_rd`  in  5  FPU destination
- `fpu_data`  in  DATA_WIDTH  FPU result
- `reg_write`  out  1  write strobe to FP register file
- `rd_addr`  out  5  write address
- `rd_data`  out  DATA_WIDTH  write data

## Operation
- FPU handshake: transfer when `fpu_valid && fpu_ready`. `fpu_ready = !full`, from registered count only; no combinational path from `fpu_valid`.
- Accepted FPU results enqueue into a FIFO of {rd, data}. Enqueue and dequeue in the same cycle are legal at any occupancy except enqueue when full.
- Write selection each cycle:
  - If `ld_valid`: the load wins. Load {rd, data} is registered to the output and the FIFO does not dequeue.
  - Else if FIFO non-empty: the head is dequeued and registered to the output.
  - Else: `reg_write` is 0 next cycle, and `rd_addr`/`rd_data` hold their values.
- Loads never stall. Back-to-back loads starve the FIFO. This is intended: the pipeline guarantees gaps.
- f0 is an ordinary writable register. There is no zero-register suppression.
- Scoreboard, `busy_vec` registered:
  - `busy[issue_rd]` sets on the edge where `issue_valid` is sampled.
  - `busy[rd_addr]` clears on the edge where `reg_write` is sampled high, which is the same edge the register file commits the data.
  - If set and clear hit the same register on the same edge, set wins.
  - Issuing to an already-busy register keeps it busy.
- Same-cycle `ld_valid` and `fpu_valid`: the load is written out and the FPU result is enqueued (if ready). Both retire in order of selection.

## Timing
- Reset: `reg_write`=0, `rd_addr`=0, `rd_data`=0, `busy_vec`=0, FIFO empty, `fpu_ready`=1. Reset mid-operation discards all buffered results and pending bits on that edge.
- Load latency: `ld_valid` sampled at edge N → `reg_write`=1 in cycle N+1 → register file updated and busy cleared at edge N+1.
- FPU latency with the FIFO empty and no load: accepted at edge N → head valid in cycle N+1 → `reg_write`=1 in cycle N+2.
- Throughput: at most one register-file write per cycle.
- `fpu_ready` deasserts in the cycle after the enqueue that fills the FIFO. It reasserts in the cycle after a dequeue from full with no enqueue.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits.

## Structure
- Shared package (`fp_wb_pkg`): `DATA_WIDTH`, the `fp_wb_entry_t` struct {logic [4:0] rd; logic [DATA_WIDTH-1:0] data}, and `FP_REG_COUNT`=32.
- One sub-module, `fp_wb_fifo`: a synchronous FIFO of `fp_wb_entry_t` with `full`/`empty`/`count`, synchronous active-high reset.
- Arbitration, output register and scoreboard live in the top module.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs → all outputs 0, `fpu_ready`=1. Assert `rst` while 3 entries are buffered and busy={f1,f2,f3} → next cycle FIFO empty, `busy_vec`=0, no write.
- Load path: issue f5 at cycle 0; `ld_valid`, rd=5, data=0x3F800000 at cycle 2 → `reg_write` cycle 3 with rd_addr=5, rd_data=0x3F800000; `busy_vec[5]` 1 through cycle 3, 0 from cycle 4.
- Priority: same-cycle load f1=0x1 and FPU f2=0x2 → writes f1 next cycle, f2 the cycle after; the FPU transfer completes (`fpu_ready`=1).
- Full/backpressure: 5 consecutive FPU results (f8–f12) while `ld_valid` is held high with 5 loads (f20–f24) → `fpu_ready` drops after the 4th accept. After the loads stop, f8–f11 are written in order, then f12 is accepted and written.
- Scoreboard collision: a write to f7 is on the output and `issue_valid`, rd=7 is presented on the same edge → `busy_vec[7]` stays 1. A subsequent write to f7 clears it.
- Wrap-around: stream 20 FPU results with no loads → written in order with one write per cycle after the 2-cycle fill; data matches a reference queue.
